// File: rtl/divvy_seq_divider.sv
// Hardware responder for the divide programs' START/DONE handshake: loads operands
// from byte memory, runs a bit-serial restoring divide with rounding, stores the result.
module divvy_seq_divider #(
    parameter int unsigned       ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] RECIP_IN  = ADDR_W'(8),
    parameter logic [ADDR_W-1:0] RECIP_OUT = ADDR_W'(10),
    parameter logic [ADDR_W-1:0] DIV_IN    = ADDR_W'(0),
    parameter logic [ADDR_W-1:0] DIV_OUT   = ADDR_W'(4)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic [1:0]        MODE,
    output logic              DONE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic              MEM_WE,
    output logic [7:0]        MEM_WDATA,
    input  logic [7:0]        MEM_RDATA
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_LOAD,
        S_DIV,
        S_ROUND,
        S_STORE,
        S_FIN
    } state_t;

    state_t             state_q;
    logic [1:0]         mode_q;
    logic [1:0]         idx_q;
    logic [4:0]         cnt_q;
    logic [15:0]        ld_q;
    logic [15:0]        dvs_q;
    logic [24:0]        dvd_q;
    logic [16:0]        rem_q;
    logic [24:0]        quo_q;
    logic [23:0]        res_q;
    logic               done_q;
    logic [ADDR_W-1:0]  addr_q;
    logic               we_q;
    logic [7:0]         wdata_q;

    logic [16:0]        rem_shift;
    logic               fits;
    logic [16:0]        rem_d;
    logic [24:0]        quo_d;
    logic [15:0]        rnd0_d;
    logic [23:0]        rnd1_d;
    logic [23:0]        res_d;
    logic [1:0]         last_idx;
    logic [ADDR_W-1:0]  out_base;
    logic               div_zero;

    assign DONE      = done_q;
    assign MEM_ADDR  = addr_q;
    assign MEM_WE    = we_q;
    assign MEM_WDATA = wdata_q;

    // One restoring step per cycle; the result is kept left-aligned in 24 bits so the
    // store loop always emits bits [23:16] regardless of mode.
    always_comb begin
        rem_shift = (rem_q << 1) | {16'b0, dvd_q[24]};
        fits      = rem_shift >= {1'b0, dvs_q};
        rem_d     = fits ? (rem_shift - {1'b0, dvs_q}) : rem_shift;
        quo_d     = {quo_q[23:0], fits};
        rnd0_d    = quo_q[16:1] + {15'b0, quo_q[0]};
        rnd1_d    = quo_q[24:1] + {23'b0, quo_q[0]};
        res_d     = mode_q[0] ? rnd1_d : {rnd0_d, 8'h00};
        last_idx  = mode_q[0] ? 2'd2 : 2'd1;
        out_base  = mode_q[0] ? DIV_OUT : RECIP_OUT;
        div_zero  = mode_q[0] ? (MEM_RDATA == 8'h00) : ({ld_q[7:0], MEM_RDATA} == 16'h0000);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
            mode_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            ld_q    <= '0;
            dvs_q   <= '0;
            dvd_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            res_q   <= '0;
            done_q  <= 1'b0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (START) state_q <= S_ARMED;
                end
                S_ARMED: begin
                    if (!START) begin
                        mode_q  <= MODE;
                        idx_q   <= '0;
                        state_q <= S_LOAD;
                        if (!MODE[1]) addr_q <= MODE[0] ? DIV_IN : RECIP_IN;
                    end
                end
                S_LOAD: begin
                    if (mode_q[1]) begin
                        state_q <= S_FIN;
                    end else if (idx_q == last_idx) begin
                        idx_q  <= '0;
                        addr_q <= out_base;
                        if (div_zero) begin
                            we_q    <= 1'b1;
                            wdata_q <= 8'hFF;
                            res_q   <= mode_q[0] ? 24'hFFFF00 : 24'hFF0000;
                            state_q <= S_STORE;
                        end else begin
                            dvs_q   <= mode_q[0] ? {8'h00, MEM_RDATA} : {ld_q[7:0], MEM_RDATA};
                            dvd_q   <= mode_q[0] ? {ld_q, 9'b0} : {1'b1, 24'b0};
                            rem_q   <= '0;
                            quo_q   <= '0;
                            cnt_q   <= mode_q[0] ? 5'd24 : 5'd16;
                            state_q <= S_DIV;
                        end
                    end else begin
                        ld_q   <= {ld_q[7:0], MEM_RDATA};
                        idx_q  <= idx_q + 2'd1;
                        addr_q <= addr_q + ADDR_W'(1);
                    end
                end
                S_DIV: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    dvd_q <= dvd_q << 1;
                    if (cnt_q == 5'd0) state_q <= S_ROUND;
                    else               cnt_q   <= cnt_q - 5'd1;
                end
                S_ROUND: begin
                    we_q    <= 1'b1;
                    wdata_q <= res_d[23:16];
                    res_q   <= {res_d[15:0], 8'h00};
                    idx_q   <= '0;
                    state_q <= S_STORE;
                end
                S_STORE: begin
                    if (idx_q == last_idx) begin
                        we_q    <= 1'b0;
                        state_q <= S_FIN;
                    end else begin
                        idx_q   <= idx_q + 2'd1;
                        addr_q  <= addr_q + ADDR_W'(1);
                        wdata_q <= res_q[23:16];
                        res_q   <= {res_q[15:0], 8'h00};
                    end
                end
                S_FIN: begin
                    // DONE becomes visible one cycle after entering FIN; only a START seen
                    // while DONE is already high re-arms.
                    if (done_q && START) begin
                        done_q  <= 1'b0;
                        state_q <= S_ARMED;
                    end else begin
                        done_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_divvy_seq_divider.sv
// Randomized scoreboard bench for divvy_seq_divider: driver pushes expected results,
// a negedge monitor pops them on each DONE rise and polices every memory write.
module tb_divvy_seq_divider;

    logic       clk = 1'b0;
    logic       RESET;
    logic       START;
    logic [1:0] MODE;
    logic       DONE;
    logic [7:0] MEM_ADDR;
    logic       MEM_WE;
    logic [7:0] MEM_WDATA;
    logic [7:0] MEM_RDATA;

    logic [7:0] mem [256];

    typedef struct {
        logic [1:0]  mode;
        logic [23:0] exp;
        int unsigned due;
    } sb_t;

    sb_t         sb[$];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned cyc = 0;
    int          cur_mode = 2;
    logic        done_prev = 1'b0;

    divvy_seq_divider #(
        .ADDR_W(8),
        .RECIP_IN(8'd8),
        .RECIP_OUT(8'd10),
        .DIV_IN(8'd0),
        .DIV_OUT(8'd4)
    ) dut (
        .CLK(clk),
        .RESET(RESET),
        .START(START),
        .MODE(MODE),
        .DONE(DONE),
        .MEM_ADDR(MEM_ADDR),
        .MEM_WE(MEM_WE),
        .MEM_WDATA(MEM_WDATA),
        .MEM_RDATA(MEM_RDATA)
    );

    always #5 clk = ~clk;

    assign MEM_RDATA = mem[MEM_ADDR];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (MEM_WE) mem[MEM_ADDR] <= MEM_WDATA;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: the full-width quotient with plain 64-bit arithmetic, then round.
    function automatic logic [23:0] ref_result(input logic [1:0] md, input logic [15:0] a,
                                               input logic [7:0] b);
        longint unsigned q;
        if (md[1]) return 24'h0;
        if (md == 2'd0) begin
            if (a == 16'h0) return 24'h00FFFF;
            q = 64'h8000_0000_0000_0000 / 64'(a);
            return {8'h00, 16'((q >> 48) + ((q >> 47) & 64'd1))};
        end
        if (b == 8'h0) return 24'hFFFFFF;
        q = (64'(a) << 48) / 64'(b);
        return 24'((q >> 40) + ((q >> 39) & 64'd1));
    endfunction

    function automatic int unsigned ref_latency(input logic [1:0] md, input logic [15:0] a,
                                                input logic [7:0] b);
        if (md[1]) return 2;
        if (md == 2'd0) return (a == 16'h0) ? 5 : 23;
        return (b == 8'h0) ? 7 : 33;
    endfunction

    always @(negedge clk) begin
        if (!RESET) begin
            if (DONE && !done_prev) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    sb_t e;
                    e = sb.pop_front();
                    check("done_latency", cyc, e.due);
                    if (e.mode == 2'd0)
                        check("recip_result", {16'h0, mem[10], mem[11]}, {16'h0, e.exp[15:0]});
                    else if (e.mode == 2'd1)
                        check("div_result", {8'h0, mem[4], mem[5], mem[6]}, {8'h0, e.exp});
                end
            end
            if (MEM_WE) begin
                logic ok;
                ok = (cur_mode == 0 && (MEM_ADDR == 8'd10 || MEM_ADDR == 8'd11)) ||
                     (cur_mode == 1 && MEM_ADDR >= 8'd4 && MEM_ADDR <= 8'd6);
                check("write_addr_legal", {31'h0, ok}, 32'd1);
            end
        end
        done_prev = DONE;
    end

    task automatic do_run(input logic [1:0] md, input logic [15:0] a, input logic [7:0] b,
                          input bit pulse);
        sb_t e;
        int  hold;
        @(negedge clk);
        if (md == 2'd0) begin
            mem[8]  = a[15:8];
            mem[9]  = a[7:0];
            mem[10] = 8'($urandom);
            mem[11] = 8'($urandom);
        end else if (md == 2'd1) begin
            mem[0] = a[15:8];
            mem[1] = a[7:0];
            mem[2] = b;
            mem[4] = 8'($urandom);
            mem[5] = 8'($urandom);
            mem[6] = 8'($urandom);
        end
        cur_mode = md[1] ? 2 : int'(md);
        START = 1'b1;
        @(negedge clk);
        check("done_cleared_on_start", {31'h0, DONE}, 32'd0);
        hold = $urandom_range(0, 2);
        repeat (hold) @(negedge clk);
        MODE  = md;
        START = 1'b0;
        e.mode = md;
        e.exp  = ref_result(md, a, b);
        e.due  = cyc + 1 + ref_latency(md, a, b);
        sb.push_back(e);
        for (int i = 0; i < 80 && !DONE; i++) begin
            if (pulse && i == 6) START = 1'b1;
            if (pulse && i == 7) START = 1'b0;
            @(negedge clk);
        end
        if (!DONE) begin
            check("done_timeout", 32'd0, 32'd1);
            if (sb.size() > 0) sb.delete(sb.size() - 1);
        end
        @(negedge clk);
    endtask

    initial begin
        logic [7:0]  snap [4];
        logic [1:0]  md;
        logic [15:0] a;
        logic [7:0]  b;
        int unsigned sel;

        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        RESET = 1'b1;
        START = 1'b0;
        MODE  = 2'd0;
        repeat (2) @(negedge clk);
        check("rst_done", {31'h0, DONE}, 32'd0);
        check("rst_we", {31'h0, MEM_WE}, 32'd0);
        check("rst_addr", {24'h0, MEM_ADDR}, 32'd0);
        check("rst_wdata", {24'h0, MEM_WDATA}, 32'd0);
        RESET = 1'b0;

        do_run(2'd0, 16'h0001, 8'h00, 1'b0);
        do_run(2'd0, 16'h0003, 8'h00, 1'b0);
        do_run(2'd0, 16'h0002, 8'h00, 1'b0);
        do_run(2'd0, 16'h0000, 8'h00, 1'b0);

        // Back-to-back: mode 1 right after mode 0 must leave bytes 8..11 alone.
        do_run(2'd0, 16'h1234, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) snap[i] = mem[8 + i];
        do_run(2'd1, 16'h0001, 8'h03, 1'b0);
        for (int i = 0; i < 4; i++) check("recip_area_kept", {24'h0, mem[8 + i]}, {24'h0, snap[i]});
        do_run(2'd1, 16'hFFFF, 8'h01, 1'b0);
        do_run(2'd1, 16'h0001, 8'h00, 1'b0);

        do_run(2'd1, 16'hBEEF, 8'h5A, 1'b1);
        do_run(2'd0, 16'h0777, 8'h00, 1'b1);
        do_run(2'd2, 16'h0000, 8'h00, 1'b0);
        do_run(2'd3, 16'h0000, 8'h00, 1'b0);

        // Abort a mode 1 run in the middle of the divide.
        @(negedge clk);
        mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h07;
        mem[4] = 8'hA5; mem[5] = 8'hA5; mem[6] = 8'hA5;
        cur_mode = 2;
        START = 1'b1;
        @(negedge clk);
        MODE  = 2'd1;
        START = 1'b0;
        repeat (13) @(negedge clk);
        RESET = 1'b1;
        #1;
        check("abort_done", {31'h0, DONE}, 32'd0);
        check("abort_we", {31'h0, MEM_WE}, 32'd0);
        check("abort_addr", {24'h0, MEM_ADDR}, 32'd0);
        @(negedge clk);
        RESET = 1'b0;
        repeat (40) @(negedge clk);
        for (int i = 4; i < 7; i++) check("abort_no_store", {24'h0, mem[i]}, 32'hA5);
        check("abort_idle_done", {31'h0, DONE}, 32'd0);
        do_run(2'd1, 16'h1234, 8'h07, 1'b0);

        for (int k = 0; k < 40; k++) begin
            sel = $urandom_range(0, 9);
            if (sel < 4)      md = 2'd0;
            else if (sel < 8) md = 2'd1;
            else              md = 2'($urandom_range(2, 3));
            a = 16'($urandom);
            b = 8'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                a = (md == 2'd0) ? 16'h0 : a;
                b = 8'h0;
            end
            do_run(md, a, b, (md == 2'd0 && a != 0) || (md == 2'd1 && b != 0) ?
                             bit'($urandom_range(0, 1)) : 1'b0);
        end

        check("scoreboard_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
